// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the pipeline stage registers. It holds the
//                per-stage control/data bundles, their widths, and the skid
//                occupancy encoding used by pipe_stage_reg.
//  Config      : PIPE_STAGE_SKID_EN (consumed by pipe_stage_reg)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   // Skid occupancy: nothing held, main entry only, main plus skid entry.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   // ---------------- IF/ID ----------------
   typedef struct packed {
      logic       pred_taken;
      logic       halt;
   } if_id_ctrl_t;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] instr;
   } if_id_data_t;

   // ---------------- ID/EX ----------------
   typedef struct packed {
      logic [1:0] ALUsrc;
      logic [1:0] memtoreg;
      logic [3:0] ALUop;
      logic       regwrite;
      logic [1:0] pcselect;
      logic [1:0] regdst;
      logic       branch;
      logic       dmemREN;
      logic       dmemWEN;
      logic       halt;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [31:0] instr;
      logic [31:0] imm;
   } id_ex_data_t;

   // ---------------- EX/MEM ----------------
   typedef struct packed {
      logic [1:0] memtoreg;
      logic       regwrite;
      logic       dmemREN;
      logic       dmemWEN;
      logic       halt;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] alu_out;
      logic [31:0] store_data;
      logic [4:0]  wsel;
   } ex_mem_data_t;

   // ---------------- MEM/WB ----------------
   typedef struct packed {
      logic [1:0] memtoreg;
      logic       regwrite;
      logic       halt;
   } mem_wb_ctrl_t;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] alu_out;
      logic [31:0] load_data;
      logic [4:0]  wsel;
   } mem_wb_data_t;

   // Widths handed to pipe_stage_reg as CTRL_W/DATA_W by each stage.
   localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
   localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
   localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
   localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
   localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
   localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
   localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
   localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);

   // Performance counter width used by all stages.
   localparam int STALL_CNT_W   = 16;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Asynchronous active-high reset, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = STALL_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic pipeline stage register with valid/ready handshake,
//                flush (control bundle zeroed, beat killed) and a saturating
//                backpressure counter.
//  Config      : PIPE_STAGE_SKID_EN - when defined, adds one skid entry and
//                registers in_ready; when undefined, single entry with a
//                combinational in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 160,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic w_stall_inc;

`ifdef PIPE_STAGE_SKID_EN

   skid_state_e       state_q,     state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q,  in_ready_d;
   logic              w_in_beat;
   logic              w_out_hs;

   // in_ready comes from a register; it is masked only while reset is held
   // so upstream sees 0 during reset and 1 immediately afterwards.
   assign in_ready  = in_ready_q & ~RST;
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign w_in_beat = in_valid & in_ready;
   assign w_out_hs  = out_valid & out_ready;

   // Occupancy next-state and entry movement; the skid entry always holds
   // the younger beat, so order is preserved when it moves to main.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d     = SKID_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            SKID_EMPTY: begin
               if (w_in_beat) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
                  state_d     = SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (w_in_beat && w_out_hs) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (w_in_beat) begin
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
                  state_d     = SKID_FULL;
               end else if (w_out_hs) begin
                  state_d     = SKID_EMPTY;
               end
            end
            SKID_FULL: begin
               // in_ready is low here, so no upstream beat can arrive.
               if (w_out_hs) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = SKID_ONE;
               end
            end
            default: begin
               state_d = SKID_EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != SKID_FULL);
   end

   // Occupancy state, entries and registered in_ready.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= SKID_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
      end
   end

`else

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // Accept when the held beat leaves this cycle or nothing is held; a
   // flush also lets upstream advance since its beat is dropped anyway.
   assign in_ready  = out_ready | ~valid_q | flush;
   assign out_valid = valid_q;
   assign out_ctrl  = ctrl_q;
   assign out_data  = data_q;

   // Flush kills the beat and zeroes control; otherwise load when ready.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (in_ready) begin
         valid_d = in_valid;
         ctrl_d  = in_ctrl;
         data_d  = in_data;
      end
   end

   // Single stage register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

`endif

   // A held beat refused downstream is a backpressure cycle unless flushed.
   assign w_stall_inc = out_valid & ~out_ready & ~flush;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .inc_i (w_stall_inc),
      .clr_i (1'b0),
      .cnt_o (stall_cnt)
   );

endmodule : pipe_stage_reg

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A queue-based model
//                of the stage (capacity 1, or 2 with PIPE_STAGE_SKID_EN)
//                predicts handshake, data order and the stall counters.
//  Config      : PIPE_STAGE_SKID_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

   localparam int CTRL_W = 16;
   localparam int DATA_W = 160;
   localparam int CNT_W  = 16;
   localparam int CNT4_W = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic              CLK;
   logic              RST;
   logic              in_valid;
   logic              in_ready;
   logic              in_ready4;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_valid4;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CTRL_W-1:0] out_ctrl4;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] out_data4;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT4_W-1:0] stall_cnt4;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT4_W)) dut4 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready4),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
      .out_data(out_data4), .stall_cnt(stall_cnt4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } beat_t;

   beat_t       q[$];
   int unsigned m_cnt;
   int unsigned m_cnt4;
   bit          m_ctrl_zero;
   int          checks;
   int          errors;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_rdy();
`ifdef PIPE_STAGE_SKID_EN
      return !RST && (q.size() < CAP);
`else
      return (q.size() == 0) || out_ready || flush;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt       = 0;
      m_cnt4      = 0;
      m_ctrl_zero = 1'b1;
   endtask

   task automatic model_edge(input bit rdy);
      if (q.size() > 0 && !out_ready && !flush) begin
         if (m_cnt  < 65535) m_cnt++;
         if (m_cnt4 < 15)    m_cnt4++;
      end
      if (flush) begin
         q.delete();
         m_ctrl_zero = 1'b1;
      end else begin
         m_ctrl_zero = 1'b0;
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) q.push_back('{c: in_ctrl, d: in_data});
      end
   endtask

   task automatic check_outputs();
      chk("out_valid",  {255'd0, out_valid},  {255'd0, q.size() > 0});
      chk("out_valid4", {255'd0, out_valid4}, {255'd0, q.size() > 0});
      if (q.size() > 0) begin
         chk("out_data",  out_data,  q[0].d);
         chk("out_ctrl",  out_ctrl,  q[0].c);
         chk("out_data4", out_data4, q[0].d);
      end
      if (m_ctrl_zero) chk("out_ctrl_zero", out_ctrl, 0);
      chk("stall_cnt",  stall_cnt,  m_cnt);
      chk("stall_cnt4", stall_cnt4, m_cnt4);
   endtask

   task automatic drive(input bit v, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input bit ordy, input bit fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   // One clock: check in_ready before the edge, outputs just after it.
   task automatic cycle();
      bit rdy;
      #1;
      rdy = exp_rdy();
      chk("in_ready",  {255'd0, in_ready},  {255'd0, rdy});
      chk("in_ready4", {255'd0, in_ready4}, {255'd0, rdy});
      @(posedge CLK);
      model_edge(rdy);
      #1;
      check_outputs();
      @(negedge CLK);
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      RST    = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      model_reset();

      // Reset values
      #2;
      check_outputs();
      @(negedge CLK);
      RST = 1'b0;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      cycle();

      // Streaming 0x1..0x8 with downstream always ready
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
         cycle();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
      chk("stream_stall_zero", stall_cnt, 0);

      // Backpressure: 0xAA held five cycles while 0xBB is offered
      drive(1'b1, 16'h00AA, 160'hAA, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h00BB, 160'hBB, 1'b0, 1'b0);
         cycle();
         chk("bp_hold_data", out_data, 160'hAA);
      end
      chk("bp_stall_five", stall_cnt, 5);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (3) cycle();

      // Flush during stall kills held beat and the incoming 0xCC
      drive(1'b1, 16'h3FFF, 160'hDD, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 16'h3FFF, 160'hCC, 1'b0, 1'b1);
      cycle();
      chk("flush_valid", {255'd0, out_valid}, 0);
      chk("flush_ctrl",  out_ctrl, 0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (2) cycle();

      // Simultaneous out handshake and new beat 0x55
      drive(1'b1, 16'h0011, 160'h11, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 16'h0055, 160'h55, 1'b1, 1'b0);
      cycle();
      chk("simul_data",  out_data, 160'h55);
      chk("simul_valid", {255'd0, out_valid}, 1);

      // Saturation of the 4-bit counter after a 20-cycle stall
      drive(1'b1, 16'h0077, 160'h77, 1'b0, 1'b0);
      repeat (20) cycle();
      chk("sat4_value", stall_cnt4, 15);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (3) cycle();

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1) == 1, CTRL_W'($urandom()), rnd_data(),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         cycle();
      end

      // Asynchronous reset while a stalled beat is held
      drive(1'b1, 16'h1234, 160'h99, 1'b0, 1'b0);
      repeat (3) cycle();
      #2;
      RST = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", {255'd0, in_ready}, {255'd0, exp_rdy()});
      @(negedge CLK);
      RST = 1'b0;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 16'h0042, 160'h42, 1'b1, 1'b0);
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipe_stage_reg

`default_nettype wire
